bcd_to_bin: RTL and testbench

- Sequential reverse double-dabble converter: a 4-digit packed BCD value becomes a 14-bit unsigned binary value.
- Inverse of the team's binary-to-BCD double-dabble block. Used to turn keypad or BCD-register entries back into binary for arithmetic and PWM/ADC compare paths.
- Also lets the double-dabble bench run round-trip checks.
- One conversion at a time, start/done handshake.

---
 rtl/bcd_to_bin.sv | 108 ++++++++++
 tb/tb_bcd_to_bin.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble: a packed BCD word becomes an unsigned binary value.
// Each shift cycle corrects every BCD nibble in parallel.

module bcd_nib_fix (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);
    // A nibble of 8 or more always has room to subtract 3 without underflowing.
    assign nib_out = (nib_in >= 4'd8) ? nib_in - 4'd3 : nib_in;
endmodule

module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [WORK_W-1:0]   work, work_nxt, work_sh, work_fix;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                err_flag, err_flag_nxt;
    logic [DIGITS-1:0]   nib_bad;
    logic                bad_digit;

    assign work_sh                = work >> 1;
    assign work_fix[BIN_W-1:0]    = work_sh[BIN_W-1:0];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        bcd_nib_fix u_fix (
            .nib_in  (work_sh [BIN_W + 4*gi +: 4]),
            .nib_out (work_fix[BIN_W + 4*gi +: 4])
        );
        assign nib_bad[gi] = (bcd[4*gi +: 4] > 4'd9);
    end

    assign bad_digit = |nib_bad;

    always_comb begin
        state_nxt    = state;
        work_nxt     = work;
        cnt_nxt      = cnt;
        err_flag_nxt = err_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nxt     = {bcd, {BIN_W{1'b0}}};
                    cnt_nxt      = '0;
                    err_flag_nxt = bad_digit;
                    state_nxt    = bad_digit ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_nxt = work_fix;
                cnt_nxt  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            work     <= work_nxt;
            cnt      <= cnt_nxt;
            err_flag <= err_flag_nxt;
        end
    end

    // done is registered off DONE, so it appears one cycle after the DONE state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= (state == DONE);
            if (state == IDLE && start)
                err <= 1'b0;
            if (state == DONE) begin
                err <= err_flag;
                bin <= err_flag ? '0 : work[BIN_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed boundary cases plus random values against a decimal model.

module tb_bcd_to_bin;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;
    int prev_bin = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal value of a packed BCD word; bad set if any digit exceeds 9.
    function automatic int ref_val(input logic [15:0] v, output bit bad);
        int r = 0;
        int m = 1;
        int d;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = int'((v >> (4*i)) & 16'hF);
            if (d > 9) bad = 1'b1;
            r += d * m;
            m *= 10;
        end
        return bad ? 0 : r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        int x = n;
        for (int i = 0; i < 4; i++) begin
            r = r | (16'(x % 10) << (4*i));
            x = x / 10;
        end
        return r;
    endfunction

    // One full conversion: latency, busy length, err clear, result and done width.
    task automatic run(input logic [15:0] v, input string tag);
        bit bad;
        int exp_bin;
        int lat = 0;
        int busy_cnt = 0;
        exp_bin = ref_val(v, bad);
        @(negedge clk);
        start = 1'b1;
        bcd   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd   = 16'($urandom);
        chk({tag, " err_clr"}, int'(err), 0);
        chk({tag, " bin_hold"}, int'(bin), prev_bin);
        if (busy) busy_cnt++;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (busy) busy_cnt++;
        end
        chk({tag, " latency"}, lat, bad ? 1 : 15);
        chk({tag, " busy_len"}, busy_cnt, bad ? 0 : 14);
        chk({tag, " bin"}, int'(bin), exp_bin);
        chk({tag, " err"}, int'(err), int'(bad));
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, int'(done), 0);
        prev_bin = exp_bin;
    endtask

    initial begin
        int ndone;
        int got;
        logic [15:0] v;
        rst   = 1'b0;
        start = 1'b0;
        bcd   = '0;
        #12;
        chk("rst bin",  int'(bin),  0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err",  int'(err),  0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle busy", int'(busy), 0);
        chk("idle done", int'(done), 0);
        chk("idle bin",  int'(bin),  0);

        run(16'h0000, "zero");
        run(16'h1234, "h1234");
        run(16'h9999, "h9999");
        run(16'h0009, "h0009");
        run(16'h0010, "h0010");
        run(16'h1000, "h1000");
        run(16'h12A4, "h12A4");
        run(16'h0042, "h0042");

        // Second start 5 cycles into a conversion must be dropped.
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h0777;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        got   = -1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done) begin ndone++; got = int'(bin); end
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) begin ndone++; got = int'(bin); end
        end
        chk("busy_start ndone", ndone, 1);
        chk("busy_start bin", got, 777);
        prev_bin = 777;

        // Reset 7 cycles into a conversion: outputs clear at once, no done.
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst bin",  int'(bin),  0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst err",  int'(err),  0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        prev_bin = 0;
        run(16'h0005, "after_rst");

        for (int i = 0; i < 120; i++) begin
            v = to_bcd(int'($urandom_range(0, 9999)));
            run(v, "rand_valid");
        end
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom);
            run(v, "rand_raw");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
